uart_byte_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_byte_rx_if.sv | 19 +
 rtl/uart_baud_tick.sv | 34 +++
 rtl/uart_byte_rx.sv | 147 ++++++++++++++
 tb/tb_uart_byte_rx.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud_set codes, FSM state encodings and the oversample divider function.
// Used by both the byte receiver and the byte transmitter.
package uart_pkg;

  localparam int TICKS_PER_BIT = 16;
  localparam int DIV_W         = 16;

  typedef enum logic [2:0] {
    BAUD_9600   = 3'd0,
    BAUD_19200  = 3'd1,
    BAUD_38400  = 3'd2,
    BAUD_57600  = 3'd3,
    BAUD_115200 = 3'd4
  } baud_e;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } fsm_state_e;

  // Clock cycles per oversample tick; codes 5..7 fall back to 9600.
  function automatic logic [DIV_W-1:0] baud_div(input int clk_freq, input logic [2:0] code);
    int baud;
    case (code)
      BAUD_19200:  baud = 19200;
      BAUD_38400:  baud = 38400;
      BAUD_57600:  baud = 57600;
      BAUD_115200: baud = 115200;
      default:     baud = 9600;
    endcase
    return DIV_W'(clk_freq / (baud * TICKS_PER_BIT));
  endfunction

endpackage

// File: rtl/uart_byte_rx_if.sv
// Signal bundle between a serial line driver/byte consumer (master) and the uart_byte_rx receiver (slave).
interface uart_byte_rx_if;
  logic       rs232_rx;
  logic [2:0] baud_set;
  logic [7:0] data_byte;
  logic       rx_done;
  logic       frame_err;
  logic       uart_state;

  modport master (
    output rs232_rx, baud_set,
    input  data_byte, rx_done, frame_err, uart_state
  );

  modport slave (
    input  rs232_rx, baud_set,
    output data_byte, rx_done, frame_err, uart_state
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: divider is cleared and the baud code latched on clr, one-cycle tick at DIV-1.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [2:0] baud_set,
  output logic       tick
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= baud_div(CLK_FREQ, BAUD_9600);
      cnt_q <= '0;
    end else if (clr) begin
      div_q <= baud_div(CLK_FREQ, baud_set);
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

  assign tick = (cnt_q == div_q - DIV_W'(1));

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver with 16x oversampling, false-start rejection and stop-bit framing check.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 vote at s_cnt 7/8/9 instead of a single s_cnt 8 sample.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = TICKS_PER_BIT
) (
  input logic           clk,
  input logic           rst,
  uart_byte_rx_if.slave bus
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [SW-1:0] S_PRE    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_DECIDE = SW'(OVERSAMPLE / 2 + 1);
`else
  localparam logic [SW-1:0] S_DECIDE = S_MID;
`endif

  fsm_state_e    state_q, state_d;
  logic [SW-1:0] s_cnt_q, s_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_byte_q, data_byte_d;
  logic          rx_done_q, rx_done_d;
  logic          frame_err_q, frame_err_d;
  logic          sync1_q, rx_s, rx_d;
  logic          start_edge, clr, tick, sample, bit_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      sync1_q <= bus.rs232_rx;
      rx_s    <= sync1_q;
      rx_d    <= rx_s;
    end
  end

  assign start_edge = rx_d & ~rx_s;
  assign sample     = tick && (s_cnt_q == S_DECIDE);

  uart_baud_tick #(.CLK_FREQ(CLK_FREQ)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .baud_set (bus.baud_set),
    .tick     (tick)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] vote_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vote_q <= 2'b11;
    end else if (tick && s_cnt_q == S_PRE) begin
      vote_q[0] <= rx_s;
    end else if (tick && s_cnt_q == S_MID) begin
      vote_q[1] <= rx_s;
    end
  end

  assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  // NOTE: every output of this block gets a default first, so no branch can infer a latch.
  always_comb begin
    state_d     = state_q;
    s_cnt_d     = s_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_byte_d = data_byte_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;
    clr         = 1'b0;
    if (tick) s_cnt_d = s_cnt_q + SW'(1);
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d   = START;
          s_cnt_d   = '0;
          bit_cnt_d = '0;
          clr       = 1'b1;
        end
      end
      START: begin
        if (sample && bit_val)               state_d = IDLE;
        else if (tick && s_cnt_q == S_LAST)  state_d = DATA;
      end
      DATA: begin
        if (sample) shift_d = {bit_val, shift_q[7:1]};
        if (tick && s_cnt_q == S_LAST) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Leaving at mid-stop lets a back-to-back start edge be caught.
        if (sample) begin
          state_d = IDLE;
          if (bit_val) begin
            data_byte_d = shift_q;
            rx_done_d   = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_cnt_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_byte_q <= 8'h00;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_cnt_q     <= s_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_byte_q <= data_byte_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.data_byte  = data_byte_q;
  assign bus.rx_done    = rx_done_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.uart_state = (state_q != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx: a queue of expected frame outcomes checked every cycle, plus literal pins.
`timescale 1ns/1ps
module tb_uart_byte_rx;
  import uart_pkg::*;

  localparam int CLK_FREQ = 10_000_000;
  localparam int DIV_FAST = 5;    // 10 MHz / (115200*16) = 5.43
  localparam int DIV_SLOW = 65;   // 10 MHz / (9600*16)   = 65.1
`ifdef UART_RX_MAJORITY_EN
  localparam int DECIDE_TICK = 10;
  localparam int GLITCH_BIT  = 3;  // data bit 2
`else
  localparam int DECIDE_TICK = 9;
  localparam int GLITCH_BIT  = -1;
`endif
  // Line change -> 2 sync flops + edge flop, then the stop-bit decision tick.
  localparam int LAT = 3 + (16 * 9 + DECIDE_TICK) * DIV_FAST;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_byte_rx_if u_if ();

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] value;
  } event_t;

  event_t     exp_q[$];
  logic [7:0] model_byte = 8'h00;
  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int last_done_cycle = 0;
  int prev_done_cycle = 0;
  int n_done = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) cycle++;

  initial begin : compare
    bit rst_at_edge;
    bit head_done;
    bit head_err;
    forever begin
      @(posedge clk);
      rst_at_edge = rst;
      @(negedge clk);
      if (rst_at_edge) model_byte = 8'h00;
      head_done = (exp_q.size() > 0) && !exp_q[0].is_err;
      head_err  = (exp_q.size() > 0) &&  exp_q[0].is_err;
      check("pulse_exclusive", u_if.rx_done & u_if.frame_err, 0);
      if (u_if.rx_done === 1'b1) begin
        n_done++;
        prev_done_cycle = last_done_cycle;
        last_done_cycle = cycle;
        check("rx_done_wanted", head_done, 1);
        if (head_done) begin
          model_byte = exp_q[0].value;
          void'(exp_q.pop_front());
        end
      end else if (u_if.frame_err === 1'b1) begin
        n_err++;
        check("frame_err_wanted", head_err, 1);
        if (head_err) void'(exp_q.pop_front());
      end
      check("data_byte", u_if.data_byte, model_byte);
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive_for(input logic v, input int n);
    u_if.rs232_rx = v;
    step(n);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int div,
                            input int switch_bit, input int glitch_bit);
    logic [9:0] bits;
    event_t e;
    bits     = {stop_ok, b, 1'b0};
    e.is_err = !stop_ok;
    e.value  = b;
    exp_q.push_back(e);
    for (int i = 0; i < 10; i++) begin
      if (i == switch_bit) u_if.baud_set = 3'd0;
      if (i == glitch_bit) begin
        drive_for(bits[i], 9 * div - div / 2);
        drive_for(~bits[i], div);
        drive_for(bits[i], 7 * div + div / 2);
      end else begin
        drive_for(bits[i], 16 * div);
      end
    end
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || u_if.uart_state !== 1'b0) && n < budget) begin
      step(1);
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_idle"}, u_if.uart_state, 0);
  endtask

  initial begin : main
    int start_cycle;
    int base_done;
    int base_err;
    int n;
    logic [9:0] partial;

    u_if.rs232_rx = 1'b1;
    u_if.baud_set = 3'd4;
    rst = 1'b1;
    step(3);
    check("reset_data_byte", u_if.data_byte, 8'h00);
    check("reset_rx_done", u_if.rx_done, 0);
    check("reset_frame_err", u_if.frame_err, 0);
    check("reset_uart_state", u_if.uart_state, 0);
    rst = 1'b0;
    step(2);

    check("div_50m_115200", baud_div(50_000_000, 3'd4), 27);
    check("div_50m_9600", baud_div(50_000_000, 3'd0), 325);
    check("div_50m_code7", baud_div(50_000_000, 3'd7), 325);
    check("div_bench_fast", baud_div(CLK_FREQ, 3'd4), DIV_FAST);
    check("div_bench_slow", baud_div(CLK_FREQ, 3'd0), DIV_SLOW);

    // 1: single frame at 115200
    base_done = n_done;
    start_cycle = cycle;
    send_frame(8'haa, 1'b1, DIV_FAST, -1, -1);
    wait_quiet("t1", 40 * DIV_FAST);
    check("t1_byte", u_if.data_byte, 8'haa);
    check("t1_done_count", n_done - base_done, 1);
    check("t1_latency", last_done_cycle - start_cycle, LAT);

    // 2: two back-to-back frames at 9600
    u_if.baud_set = 3'd0;
    step(4);
    base_done = n_done;
    send_frame(8'h55, 1'b1, DIV_SLOW, -1, -1);
    send_frame(8'h0f, 1'b1, DIV_SLOW, -1, -1);
    wait_quiet("t2", 40 * DIV_SLOW);
    check("t2_byte", u_if.data_byte, 8'h0f);
    check("t2_done_count", n_done - base_done, 2);
    check("t2_spacing", last_done_cycle - prev_done_cycle, 160 * DIV_SLOW);

    // 3: 5-clock glitch at 115200 is a false start
    u_if.baud_set = 3'd4;
    step(4);
    base_done = n_done;
    base_err = n_err;
    drive_for(1'b0, 5);
    u_if.rs232_rx = 1'b1;
    n = 0;
    while (u_if.uart_state !== 1'b1 && n < 10) begin step(1); n++; end
    check("t3_state_rise", u_if.uart_state, 1);
    n = 0;
    while (u_if.uart_state !== 1'b0 && n < 20 * DIV_FAST) begin step(1); n++; end
    check("t3_state_drop", u_if.uart_state, 0);
    check("t3_drop_cycles", n, DECIDE_TICK * DIV_FAST - 2);
    step(32 * DIV_FAST);
    check("t3_no_done", n_done - base_done, 0);
    check("t3_no_err", n_err - base_err, 0);

    // 4: stop bit low, then the line stays low
    base_done = n_done;
    base_err = n_err;
    send_frame(8'h3c, 1'b0, DIV_FAST, -1, -1);
    drive_for(1'b0, 48 * DIV_FAST);
    check("t4_state_while_low", u_if.uart_state, 0);
    check("t4_err_count", n_err - base_err, 1);
    check("t4_no_done", n_done - base_done, 0);
    check("t4_byte_kept", u_if.data_byte, 8'h0f);
    drive_for(1'b1, 32 * DIV_FAST);
    wait_quiet("t4", 40 * DIV_FAST);

    // 5: reset during data bit 4, then a clean frame
    base_done = n_done;
    base_err = n_err;
    partial = {1'b1, 8'h5a, 1'b0};
    for (int i = 0; i < 5; i++) drive_for(partial[i], 16 * DIV_FAST);
    drive_for(partial[5], 8 * DIV_FAST);
    rst = 1'b1;
    step(1);
    check("t5_rst_data_byte", u_if.data_byte, 8'h00);
    check("t5_rst_rx_done", u_if.rx_done, 0);
    check("t5_rst_frame_err", u_if.frame_err, 0);
    check("t5_rst_uart_state", u_if.uart_state, 0);
    rst = 1'b0;
    drive_for(1'b1, 48 * DIV_FAST);
    check("t5_no_done", n_done - base_done, 0);
    check("t5_no_err", n_err - base_err, 0);
    send_frame(8'hc3, 1'b1, DIV_FAST, -1, -1);
    wait_quiet("t5", 40 * DIV_FAST);
    check("t5_byte", u_if.data_byte, 8'hc3);

    // 6: baud_set changes mid-frame (and, with voting, a one-tick glitch in data bit 2)
    base_done = n_done;
    send_frame(8'h81, 1'b1, DIV_FAST, 2, GLITCH_BIT);
    wait_quiet("t6", 40 * DIV_FAST);
    u_if.baud_set = 3'd4;
    check("t6_byte", u_if.data_byte, 8'h81);
    check("t6_done_count", n_done - base_done, 1);

    step(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
